// File: rtl/reg_bus_pkg.sv
// Shared definitions for the peripheral register bus initiator:
// state encoding, command byte field positions and default widths.
package reg_bus_pkg;

   localparam int ADDR_W_DEF    = 6;
   localparam int DATA_W_DEF    = 8;

   localparam int CMD_RW_BIT    = 7;
   localparam int CMD_BURST_BIT = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_WDATA    = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_SEND  = 3'd4,
      ST_DRAIN    = 3'd5
   } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Register bus initiator. Turns byte frames from the serial front-end into
// single-cycle read/write strobes towards the register file and returns read
// data through a valid/ready byte handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   frame_active        chip-select window; low aborts the frame
//   rx_valid, rx_data   received byte strobe and data
//   tx_data, tx_valid,  read byte back to the front-end, held until tx_ready
//   tx_ready
//   read, write         one-cycle register strobes
//   addr, data_write    register address and write data
//   data_read           combinational read data for addr
//   ovf_err             sticky: extra byte in a non-burst frame
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no frame; entering a frame clears ovf_err
// ST_CMD      | waiting for the command byte
// ST_WDATA    | waiting for write data bytes
// ST_RD_ISSUE | read strobe is high this cycle; capture data_read
// ST_RD_SEND  | tx_valid held until tx_ready
// ST_DRAIN    | transfer done; any further byte flags ovf_err
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_active,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_read,
   output logic [DATA_W-1:0] data_write,
   output logic              ovf_err
);

   state_t              state_q, state_d;
   logic                burst_q, burst_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_write_q, data_write_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic                ovf_q, ovf_d;

   always_comb begin
      state_d      = state_q;
      burst_d      = burst_q;
      addr_d       = addr_q;
      data_write_d = data_write_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      ovf_d        = ovf_q;
      read_d       = 1'b0;
      write_d      = 1'b0;

      // Burst writes step the address once the strobe cycle has used it.
      if (write_q && burst_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      if (!frame_active) begin
         state_d    = ST_IDLE;
         tx_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_CMD;
               ovf_d   = 1'b0;
            end
            ST_CMD: begin
               if (rx_valid) begin
                  addr_d  = rx_data[ADDR_W-1:0];
                  burst_d = rx_data[CMD_BURST_BIT];
                  if (rx_data[CMD_RW_BIT]) begin
                     state_d = ST_WDATA;
                  end else begin
                     state_d = ST_RD_ISSUE;
                     read_d  = 1'b1;
                  end
               end
            end
            ST_WDATA: begin
               if (rx_valid) begin
                  write_d      = 1'b1;
                  data_write_d = rx_data;
                  if (!burst_q) begin
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_RD_ISSUE: begin
               tx_data_d  = data_read;
               tx_valid_d = 1'b1;
               state_d    = ST_RD_SEND;
            end
            ST_RD_SEND: begin
               // Bytes arriving here are dummy clock-out bytes and are ignored.
               if (tx_ready) begin
                  tx_valid_d = 1'b0;
                  if (burst_q) begin
                     addr_d  = addr_q + ADDR_W'(1);
                     read_d  = 1'b1;
                     state_d = ST_RD_ISSUE;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (rx_valid) begin
                  ovf_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         burst_q      <= 1'b0;
         addr_q       <= '0;
         data_write_q <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_q      <= burst_d;
         addr_q       <= addr_d;
         data_write_q <= data_write_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         read_q       <= read_d;
         write_q      <= write_d;
         ovf_q        <= ovf_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign read       = read_q;
   assign write      = write_q;
   assign addr       = addr_q;
   assign data_write = data_write_q;
   assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: table of write frames plus hand-written read,
// abort and reset sequences. Expected strobes go into a scoreboard queue when
// the stimulus is driven and are popped by a monitor when the DUT strobes.
module tb_reg_bus_master;

   logic       clk;
   logic       rst;
   logic       frame_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic [7:0] data_read;
   logic [7:0] data_write;
   logic       ovf_err;

   logic [7:0] mem [64];

   int total_cnt = 0;
   int pass_cnt  = 0;
   int rd_seen   = 0;
   int wr_seen   = 0;

   typedef struct {
      logic            is_wr;
      logic [5:0]      a;
      logic [7:0]      d;
   } exp_t;

   exp_t sbq [$];

   typedef struct {
      logic [7:0]      cmd;
      int              nb;
      logic [2:0][7:0] b;
      logic [2:0][5:0] ea;
      int              nw;
      logic            ovf;
   } wvec_t;

   wvec_t vecs [4];

   reg_bus_master #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_active (frame_active),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .read         (read),
      .write        (write),
      .addr         (addr),
      .data_read    (data_read),
      .data_write   (data_write),
      .ovf_err      (ovf_err)
   );

   assign data_read = mem[addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic start_frame();
      frame_active = 1'b1;
      tick();
      chk("ovf_clear_on_start", ovf_err, 0);
   endtask

   task automatic do_write(input wvec_t v);
      start_frame();
      send(v.cmd);
      chk("cmd_no_write", write, 0);
      for (int i = 0; i < v.nb; i++) begin
         if (i < v.nw) sbq.push_back('{1'b1, v.ea[i], v.b[i]});
         send(v.b[i]);
         chk("write_latency", write, (i < v.nw) ? 1 : 0);
         tick();
      end
      chk("ovf_err", ovf_err, v.ovf);
      frame_active = 1'b0;
      tick();
      chk("ovf_sticky", ovf_err, v.ovf);
      tick();
   endtask

   task automatic do_read(input logic [7:0] cmd, input int n, input int hold);
      logic [5:0] a;
      a = cmd[5:0];
      start_frame();
      sbq.push_back('{1'b0, a, 8'h00});
      send(cmd);
      for (int k = 0; k < n; k++) begin
         chk("read_strobe", read, 1);
         chk("read_tx_not_yet", tx_valid, 0);
         tick();
         chk("read_single_cycle", read, 0);
         chk("tx_valid", tx_valid, 1);
         chk("tx_data", tx_data, mem[a]);
         send(8'hFF);
         repeat (hold) tick();
         chk("tx_valid_hold", tx_valid, 1);
         chk("tx_data_hold", tx_data, mem[a]);
         if (cmd[6] && k == n - 1) begin
            frame_active = 1'b0;
            tick();
            chk("abort_drops_tx_valid", tx_valid, 0);
         end else begin
            if (cmd[6]) begin
               a = a + 6'd1;
               sbq.push_back('{1'b0, a, 8'h00});
            end
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            chk("tx_valid_after_ready", tx_valid, 0);
         end
      end
      frame_active = 1'b0;
      tick();
      tick();
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   initial begin
      exp_t e;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 1);
      mem[3] = 8'h7E;
      forever begin
         @(negedge clk);
         if (!rst && (read || write)) begin
            chk("read_write_exclusive", read & write, 0);
            if (write) wr_seen++;
            if (read)  rd_seen++;
            if (sbq.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_strobe: read=%0b write=%0b addr=0x%0h, none expected at %0t",
                        read, write, addr, $time);
            end else begin
               e = sbq.pop_front();
               chk("strobe_kind", write, e.is_wr);
               chk("strobe_addr", addr, e.a);
               if (e.is_wr) begin
                  chk("write_data", data_write, e.d);
                  mem[e.a] = e.d;
               end
            end
         end
      end
   end

   initial begin
      int rd_before;
      int wr_before;

      vecs[0] = '{cmd:8'h85, nb:1, b:{8'h00, 8'h00, 8'h3C}, ea:{6'h00, 6'h00, 6'h05}, nw:1, ovf:1'b0};
      vecs[1] = '{cmd:8'h81, nb:2, b:{8'h00, 8'hBB, 8'hAA}, ea:{6'h00, 6'h00, 6'h01}, nw:1, ovf:1'b1};
      vecs[2] = '{cmd:8'hFE, nb:3, b:{8'h33, 8'h22, 8'h11}, ea:{6'h00, 6'h3F, 6'h3E}, nw:3, ovf:1'b0};
      vecs[3] = '{cmd:8'hC0, nb:2, b:{8'h00, 8'h02, 8'h01}, ea:{6'h00, 6'h01, 6'h00}, nw:2, ovf:1'b0};

      rst          = 1'b1;
      frame_active = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      tx_ready     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_read", read, 0);
      chk("rst_write", write, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data_write", data_write, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_ovf", ovf_err, 0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) do_write(vecs[v]);

      do_read(8'h03, 1, 4);
      do_read(8'h7F, 2, 1);

      // Command byte then frame abort: no strobe, then a normal read.
      wr_before = wr_seen;
      start_frame();
      send(8'h82);
      frame_active = 1'b0;
      tick();
      repeat (3) tick();
      chk("abort_no_write", wr_seen, wr_before);
      do_read(8'h04, 1, 0);

      // Reset while the read byte is waiting for tx_ready.
      start_frame();
      sbq.push_back('{1'b0, 6'h03, 8'h00});
      send(8'h03);
      chk("rst_seq_read", read, 1);
      tick();
      chk("rst_seq_tx_valid", tx_valid, 1);
      rst = 1'b1;
      #1;
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_addr", addr, 0);
      chk("midrst_data_write", data_write, 0);
      chk("midrst_read", read, 0);
      chk("midrst_write", write, 0);
      chk("midrst_ovf", ovf_err, 0);
      rd_before = rd_seen;
      wr_before = wr_seen;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) tick();
      chk("post_rst_no_read", rd_seen, rd_before);
      chk("post_rst_no_write", wr_seen, wr_before);
      chk("post_rst_tx_valid", tx_valid, 0);
      frame_active = 1'b0;
      repeat (2) tick();

      chk("scoreboard_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
